branch_predictor_btb: RTL and testbench
=======================================

Name: branch_predictor_btb

Overview:
- Parametrised dynamic branch predictor for the 5-stage pipelined CPU.
- Replaces static resolve-in-ID branching with a fetch-stage prediction: a direct-mapped branch target buffer (BTB) plus saturating-counter direction prediction, in either bimodal or gshare mode.
- The IF stage looks up PCF combinationally. The resolving stage feeds back actual outcomes through the update port.
- Keeps saturating mispredict and update statistics for the testbench memory dump.

Parameters:
- ADDR_W, 32, PC/target width in bits.
- INDEX_W, 4, log2 of table entries (ENTRIES = 2^INDEX_W).
- CTR_W, 2, saturating direction-counter width, 1..4.
- MODE, 0, 0 = bimodal (counter per BTB entry); 1 = gshare (separate PHT indexed by PC index XOR GHR).
- CNT_W, 16, statistics counter width.

Ports:
- clk  input  1  rising-edge clock.
- bpRst  input  1  synchronous active-high reset.
- pcF  input  ADDR_W  fetch PC to look up.
- hitF  output  1  BTB valid and tag match for pcF.
- predTakenF  output  1  predicted taken.
- predTargetF  output  ADDR_W  predicted next PC.
- updEn  input  1  commit one resolved branch this cycle.
- updPC  input  ADDR_W  PC of the resolved branch.
- updTaken  input  1  actual direction.
- updTarget  input  ADDR_W  actual taken target.
- updPredTaken  input  1  prediction originally made for this branch.
- updPredTarget  input  ADDR_W  target originally predicted.
- updCnt  output  CNT_W  number of updates committed.
- mispredCnt  output  CNT_W  number of mispredictions.

Behaviour:
- Address fields:
  - idx = pc[INDEX_W+1:2]; tag = pc[ADDR_W-1:INDEX_W+2]; pc[1:0] ignored.
  - Each BTB entry holds valid, tag, target, and (MODE=0 only) a counter.
- Lookup is purely combinational, zero latency:
  - hitF = valid[idx] && tag match.
  - Counter source: MODE=0 uses the entry counter; MODE=1 uses PHT[idx ^ GHR].
  - predTakenF = hitF && counter MSB.
  - predTargetF = predTakenF ? target[idx] : pcF + 4, with the add modulo 2^ADDR_W.
- Updates are sequential and take effect at the rising edge where updEn=1. A lookup in the same cycle sees pre-update state; there is no bypass.
- BTB fields, both modes:
  - updTaken=1: write valid=1, tag, and updTarget at idx(updPC), overwriting any alias.
  - updTaken=0: BTB fields are unchanged, and a not-taken miss never allocates.
- Direction counter, MODE=0:
  - Taken, miss (or alias replacement): counter := 2^(CTR_W-1) (weakly taken).
  - Taken, hit: counter increments, saturating at 2^CTR_W-1.
  - Not taken, hit: counter decrements, saturating at 0.
  - Not taken, miss: no change.
- Direction counter, MODE=1:
  - PHT[idx(updPC) ^ GHR] increments or decrements with saturation on every update, hit or miss.
  - GHR is INDEX_W bits and becomes {GHR[INDEX_W-2:0], updTaken} at the same edge.
  - History is non-speculative: it is updated at commit only. Lookup and the update PHT index use the current GHR value.
- Statistics:
  - updCnt increments on each updEn.
  - mispredCnt increments when updEn && (updPredTaken != updTaken || (updTaken && updPredTaken && updPredTarget != updTarget)).
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset (bpRst=1 at a rising edge, priority over updEn):
  - All valid := 0; MODE=0 counters := 2^(CTR_W-1); PHT := 2^(CTR_W-1)-1 (weakly not taken); GHR := 0; updCnt := 0; mispredCnt := 0.
  - An update coincident with reset is discarded.
  - Outputs after reset: hitF=0, predTakenF=0, predTargetF=pcF+4, counts 0.
  - Reset mid-operation behaves identically, with no residual state.
- No X propagation: all tables are reset explicitly. Unused storage (MODE-dependent) may be optimised away.

Test Plan:
1. Defaults, bimodal, after reset: pcF=0x00400010 -> hitF=0, predTakenF=0, predTargetF=0x00400014; pcF=0xFFFFFFFC -> predTargetF=0x00000000.
2. Allocate: updEn, updPC=0x00400010, updTaken=1, updTarget=0x00400040, updPredTaken=0 -> same cycle lookup still misses. Next cycle: hitF=1, predTakenF=1, predTargetF=0x00400040; mispredCnt=1, updCnt=1.
3. Saturation:
   - 3 further taken updates: counter 3, stays 3.
   - 2 not-taken: counter 1 -> predTakenF=0 with hitF=1, predTargetF=0x00400014.
   - 2 more not-taken: counter stays 0.
4. Aliasing: after scenario 2, pcF=0x00400050 (same idx 4, different tag) -> hitF=0. A taken update of 0x00400050 to target 0x00400100 replaces the entry -> 0x00400010 now misses and 0x00400050 hits with counter 2.
5. Gshare (MODE=1): after reset, 4 taken updates at 0x00400010 -> GHR=4'b1111. The PHT entries touched are idx 4^0, 4^1, 4^3, 4^7, each going 1->2. Lookup of a hit pc uses PHT[4^15]=1 -> predTakenF=0.
6. Reset and statistics:
   - Assert bpRst together with updEn mid-sequence -> the update is dropped and all lookups miss next cycle; counts are 0.
   - With CNT_W=2, 5 mispredicting updates -> mispredCnt=3, updCnt=3.

Source files
------------

// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: direct-mapped BTB with bimodal or gshare direction
// prediction, zero-latency fetch lookup and commit-time statistics.
module branch_predictor_btb #(
   parameter int ADDR_W  = 32,
   parameter int INDEX_W = 4,
   parameter int CTR_W   = 2,
   parameter int MODE    = 0,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              bpRst,
   input  logic [ADDR_W-1:0] pcF,
   output logic              hitF,
   output logic              predTakenF,
   output logic [ADDR_W-1:0] predTargetF,
   input  logic              updEn,
   input  logic [ADDR_W-1:0] updPC,
   input  logic              updTaken,
   input  logic [ADDR_W-1:0] updTarget,
   input  logic              updPredTaken,
   input  logic [ADDR_W-1:0] updPredTarget,
   output logic [CNT_W-1:0]  updCnt,
   output logic [CNT_W-1:0]  mispredCnt
);
   localparam int ENTRIES = 1 << INDEX_W;
   localparam int TAG_W   = ADDR_W - INDEX_W - 2;
   localparam logic [CTR_W-1:0] WEAK_T  = CTR_W'(1 << (CTR_W - 1));
   localparam logic [CTR_W-1:0] WEAK_NT = WEAK_T - CTR_W'(1);

   logic              validT [ENTRIES];
   logic [TAG_W-1:0]  tagT   [ENTRIES];
   logic [ADDR_W-1:0] tgtT   [ENTRIES];
   logic [CTR_W-1:0]  ctrT   [ENTRIES];
   logic [CTR_W-1:0]  phtT   [ENTRIES];
   logic [INDEX_W-1:0] ghr;

   logic [INDEX_W-1:0] idxF, idxU, phtU;
   logic [TAG_W-1:0]   tagF, tagU;
   logic [CTR_W-1:0]   ctrF;
   logic               hitU;
   logic               mispred;
   logic               unusedLow;

   function automatic logic [CTR_W-1:0] satStep(
      input logic [CTR_W-1:0] c,
      input logic             up
   );
      if (up)
         return (c == '1) ? c : c + CTR_W'(1);
      return (c == '0) ? c : c - CTR_W'(1);
   endfunction

   assign idxF = pcF[INDEX_W+1:2];
   assign tagF = pcF[ADDR_W-1:INDEX_W+2];
   assign idxU = updPC[INDEX_W+1:2];
   assign tagU = updPC[ADDR_W-1:INDEX_W+2];
   assign phtU = idxU ^ ghr;
   assign unusedLow = ^updPC[1:0];

   // Fetch lookup sees only committed state; no same-cycle bypass.
   assign hitF = validT[idxF] && (tagT[idxF] == tagF);
   assign ctrF = (MODE == 0) ? ctrT[idxF] : phtT[idxF ^ ghr];
   assign predTakenF = hitF && ctrF[CTR_W-1];
   assign predTargetF = predTakenF ? tgtT[idxF] : pcF + ADDR_W'(4);

   assign hitU = validT[idxU] && (tagT[idxU] == tagU);
   assign mispred = (updPredTaken != updTaken) ||
                    (updTaken && updPredTaken &&
                     (updPredTarget != updTarget));

   always_ff @(posedge clk) begin
      if (bpRst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            validT[i] <= 1'b0;
            tagT[i]   <= '0;
            tgtT[i]   <= '0;
            ctrT[i]   <= WEAK_T;
            phtT[i]   <= WEAK_NT;
         end
         ghr        <= '0;
         updCnt     <= '0;
         mispredCnt <= '0;
      end else if (updEn) begin
         if (updTaken) begin
            validT[idxU] <= 1'b1;
            tagT[idxU]   <= tagU;
            tgtT[idxU]   <= updTarget;
         end
         if (MODE == 0) begin
            // A taken miss (new or aliased entry) restarts at weakly taken.
            if (updTaken && !hitU)
               ctrT[idxU] <= WEAK_T;
            else if (hitU)
               ctrT[idxU] <= satStep(ctrT[idxU], updTaken);
         end else begin
            phtT[phtU] <= satStep(phtT[phtU], updTaken);
            ghr        <= {ghr[INDEX_W-2:0], updTaken};
         end
         if (updCnt != '1)
            updCnt <= updCnt + CNT_W'(1);
         if (mispred && (mispredCnt != '1))
            mispredCnt <= mispredCnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb_branch_predictor_btb: directed table, gshare/saturation sequences and
// randomized traffic against a behavioural predictor model.
module tb_branch_predictor_btb;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        bpRst = 1'b1, updEn = 1'b0, updTaken = 1'b0;
   logic        updPredTaken = 1'b0;
   logic [31:0] pcF = '0, updPC = '0, updTarget = '0, updPredTarget = '0;

   logic        hit0, tk0, hit1, tk1, hit2, tk2;
   logic [31:0] tgt0, tgt1, tgt2;
   logic [15:0] uc0, mc0, uc1, mc1;
   logic [1:0]  uc2, mc2;

   branch_predictor_btb #(.MODE(0)) dutBim (
      .clk(clk), .bpRst(bpRst), .pcF(pcF),
      .hitF(hit0), .predTakenF(tk0), .predTargetF(tgt0),
      .updEn(updEn), .updPC(updPC), .updTaken(updTaken),
      .updTarget(updTarget), .updPredTaken(updPredTaken),
      .updPredTarget(updPredTarget),
      .updCnt(uc0), .mispredCnt(mc0));

   branch_predictor_btb #(.MODE(1)) dutGsh (
      .clk(clk), .bpRst(bpRst), .pcF(pcF),
      .hitF(hit1), .predTakenF(tk1), .predTargetF(tgt1),
      .updEn(updEn), .updPC(updPC), .updTaken(updTaken),
      .updTarget(updTarget), .updPredTaken(updPredTaken),
      .updPredTarget(updPredTarget),
      .updCnt(uc1), .mispredCnt(mc1));

   branch_predictor_btb #(.MODE(0), .CNT_W(2)) dutSmall (
      .clk(clk), .bpRst(bpRst), .pcF(pcF),
      .hitF(hit2), .predTakenF(tk2), .predTargetF(tgt2),
      .updEn(updEn), .updPC(updPC), .updTaken(updTaken),
      .updTarget(updTarget), .updPredTaken(updPredTaken),
      .updPredTarget(updPredTarget),
      .updCnt(uc2), .mispredCnt(mc2));

   int nErr = 0;
   int nChk = 0;

   // Behavioural model: BTB contents are shared by both modes.
   bit          mV   [16];
   logic [31:0] mTag [16];
   logic [31:0] mTgt [16];
   int          mCtr [16];
   int          pht  [16];
   int          ghr;
   int          stU, stM, stU2, stM2;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nChk++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic void look(input int mode, input logic [31:0] pc,
                                output bit h, output bit t,
                                output logic [31:0] g);
      int i, c;
      i = int'((pc >> 2) % 16);
      h = mV[i] && (mTag[i] == (pc >> 6));
      c = (mode == 0) ? mCtr[i] : pht[i ^ ghr];
      t = h && (c >= 2);
      g = t ? mTgt[i] : pc + 32'd4;
   endfunction

   task automatic modelUpdate();
      int i, k;
      bit h, wrong;
      if (bpRst) begin
         for (int j = 0; j < 16; j++) begin
            mV[j] = 0; mCtr[j] = 2; pht[j] = 1;
         end
         ghr = 0; stU = 0; stM = 0; stU2 = 0; stM2 = 0;
         return;
      end
      if (!updEn) return;
      i = int'((updPC >> 2) % 16);
      h = mV[i] && (mTag[i] == (updPC >> 6));
      if (updTaken) begin
         mCtr[i] = h ? ((mCtr[i] < 3) ? mCtr[i] + 1 : 3) : 2;
         mV[i] = 1; mTag[i] = updPC >> 6; mTgt[i] = updTarget;
      end else if (h) begin
         mCtr[i] = (mCtr[i] > 0) ? mCtr[i] - 1 : 0;
      end
      k = i ^ ghr;
      if (updTaken) pht[k] = (pht[k] < 3) ? pht[k] + 1 : 3;
      else          pht[k] = (pht[k] > 0) ? pht[k] - 1 : 0;
      ghr = (ghr * 2 + int'(updTaken)) % 16;
      wrong = (updTaken != updPredTaken) ||
              (updTaken && (updPredTarget != updTarget));
      stU  = (stU < 65535) ? stU + 1 : 65535;
      stU2 = (stU2 < 3) ? stU2 + 1 : 3;
      if (wrong) begin
         stM  = (stM < 65535) ? stM + 1 : 65535;
         stM2 = (stM2 < 3) ? stM2 + 1 : 3;
      end
   endtask

   task automatic checkModel();
      bit h, t;
      logic [31:0] g;
      look(0, pcF, h, t, g);
      chk("bim_hit", 32'(hit0), 32'(h));
      chk("bim_taken", 32'(tk0), 32'(t));
      chk("bim_target", tgt0, g);
      chk("small_hit", 32'(hit2), 32'(h));
      chk("small_taken", 32'(tk2), 32'(t));
      chk("small_target", tgt2, g);
      look(1, pcF, h, t, g);
      chk("gsh_hit", 32'(hit1), 32'(h));
      chk("gsh_taken", 32'(tk1), 32'(t));
      chk("gsh_target", tgt1, g);
      chk("bim_updCnt", 32'(uc0), stU);
      chk("bim_mispredCnt", 32'(mc0), stM);
      chk("gsh_updCnt", 32'(uc1), stU);
      chk("gsh_mispredCnt", 32'(mc1), stM);
      chk("small_updCnt", 32'(uc2), stU2);
      chk("small_mispredCnt", 32'(mc2), stM2);
   endtask

   task automatic drive(input bit r, input bit e, input logic [31:0] pf,
                        input logic [31:0] up, input bit t,
                        input logic [31:0] tg, input bit pt,
                        input logic [31:0] ptg);
      bpRst = r; updEn = e; pcF = pf; updPC = up; updTaken = t;
      updTarget = tg; updPredTaken = pt; updPredTarget = ptg;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      modelUpdate();
      @(negedge clk);
   endtask

   typedef struct {
      bit          r, e;
      logic [31:0] pf, up;
      bit          t;
      logic [31:0] tg;
      bit          pt;
      logic [31:0] ptg;
      bit          eh, et;
      logic [31:0] eg;
      int          eu, em;
   } vec_t;

   function automatic vec_t mk(bit r, bit e, logic [31:0] pf,
                               logic [31:0] up, bit t, logic [31:0] tg,
                               bit pt, logic [31:0] ptg, bit eh, bit et,
                               logic [31:0] eg, int eu, int em);
      vec_t v;
      v.r = r; v.e = e; v.pf = pf; v.up = up; v.t = t; v.tg = tg;
      v.pt = pt; v.ptg = ptg; v.eh = eh; v.et = et; v.eg = eg;
      v.eu = eu; v.em = em;
      return v;
   endfunction

   function automatic logic [31:0] randPc();
      return 32'h0040_0000 | ($urandom_range(0, 2) << 6) |
             ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
   endfunction

   localparam logic [31:0] A  = 32'h0040_0010;
   localparam logic [31:0] A4 = 32'h0040_0014;
   localparam logic [31:0] T  = 32'h0040_0040;
   localparam logic [31:0] B  = 32'h0040_0050;
   localparam logic [31:0] B4 = 32'h0040_0054;
   localparam logic [31:0] TB = 32'h0040_0100;

   vec_t tv[$];

   initial begin
      tv.push_back(mk(0,0,A,0,0,0,0,0, 0,0,A4, 0,0));
      tv.push_back(mk(0,0,32'hFFFF_FFFC,0,0,0,0,0, 0,0,32'h0, 0,0));
      tv.push_back(mk(0,1,A,A,1,T,0,A4, 0,0,A4, 0,0));
      tv.push_back(mk(0,0,A,0,0,0,0,0, 1,1,T, 1,1));
      tv.push_back(mk(0,1,A,A,1,T,1,T, 1,1,T, 1,1));
      tv.push_back(mk(0,1,A,A,1,T,1,T, 1,1,T, 2,1));
      tv.push_back(mk(0,1,A,A,1,T,1,T, 1,1,T, 3,1));
      tv.push_back(mk(0,1,A,A,0,0,1,T, 1,1,T, 4,1));
      tv.push_back(mk(0,1,A,A,0,0,1,T, 1,1,T, 5,2));
      tv.push_back(mk(0,1,A,A,0,0,0,A4, 1,0,A4, 6,3));
      tv.push_back(mk(0,1,A,A,0,0,0,A4, 1,0,A4, 7,3));
      tv.push_back(mk(0,0,A,0,0,0,0,0, 1,0,A4, 8,3));
      tv.push_back(mk(0,1,A,A,1,T,0,A4, 1,0,A4, 8,3));
      tv.push_back(mk(0,0,A,0,0,0,0,0, 1,0,A4, 9,4));
      tv.push_back(mk(0,0,B,0,0,0,0,0, 0,0,B4, 9,4));
      tv.push_back(mk(0,1,B,B,1,TB,0,B4, 0,0,B4, 9,4));
      tv.push_back(mk(0,0,A,0,0,0,0,0, 0,0,A4, 10,5));
      tv.push_back(mk(0,0,B,0,0,0,0,0, 1,1,TB, 10,5));
      tv.push_back(mk(0,1,B,B,0,0,1,TB, 1,1,TB, 10,5));
      tv.push_back(mk(0,0,B,0,0,0,0,0, 1,0,B4, 11,6));
      tv.push_back(mk(0,1,B,B,1,TB,1,32'h0040_0200, 1,0,B4, 11,6));
      tv.push_back(mk(0,0,B,0,0,0,0,0, 1,1,TB, 12,7));
      tv.push_back(mk(1,1,B,32'h0040_0020,1,32'h0040_0300,0,0,
                      1,1,TB, 12,7));
      tv.push_back(mk(0,0,B,0,0,0,0,0, 0,0,B4, 0,0));
      tv.push_back(mk(0,0,32'h0040_0020,0,0,0,0,0,
                      0,0,32'h0040_0024, 0,0));

      @(negedge clk);
      drive(1, 0, A, 0, 0, 0, 0, 0);
      tick();

      foreach (tv[n]) begin
         drive(tv[n].r, tv[n].e, tv[n].pf, tv[n].up, tv[n].t, tv[n].tg,
               tv[n].pt, tv[n].ptg);
         chk($sformatf("vec%0d_hit", n), 32'(hit0), 32'(tv[n].eh));
         chk($sformatf("vec%0d_taken", n), 32'(tk0), 32'(tv[n].et));
         chk($sformatf("vec%0d_target", n), tgt0, tv[n].eg);
         chk($sformatf("vec%0d_updCnt", n), 32'(uc0), tv[n].eu);
         chk($sformatf("vec%0d_mispredCnt", n), 32'(mc0), tv[n].em);
         checkModel();
         tick();
      end

      // Gshare history walk plus 2-bit statistics saturation.
      drive(1, 0, A, 0, 0, 0, 0, 0);
      tick();
      for (int k = 0; k < 4; k++) begin
         drive(0, 1, A, A, 1, T, 0, A4);
         tick();
      end
      drive(0, 0, A, 0, 0, 0, 0, 0);
      chk("gsh_ghr15_hit", 32'(hit1), 32'd1);
      chk("gsh_ghr15_taken", 32'(tk1), 32'd0);
      chk("gsh_ghr15_target", tgt1, A4);
      chk("bim_after4_taken", 32'(tk0), 32'd1);
      chk("small_updCnt_sat", 32'(uc2), 32'd3);
      chk("small_mispred_sat", 32'(mc2), 32'd3);
      checkModel();
      drive(0, 1, A, A, 1, T, 0, A4);
      tick();
      drive(0, 0, A, 0, 0, 0, 0, 0);
      chk("gsh_pht11_taken", 32'(tk1), 32'd1);
      chk("gsh_pht11_target", tgt1, T);
      chk("bim_updCnt5", 32'(uc0), 32'd5);
      chk("bim_mispred5", 32'(mc0), 32'd5);
      checkModel();
      tick();

      drive(1, 0, A, 0, 0, 0, 0, 0);
      tick();
      for (int k = 0; k < 600; k++) begin
         bit r, e, t, h, pt, pred;
         logic [31:0] up, tg, pg, pf;
         r  = ($urandom_range(0, 49) == 0);
         e  = ($urandom_range(0, 3) != 0);
         up = randPc();
         t  = $urandom_range(0, 1);
         tg = 32'h0040_1000 | ($urandom_range(0, 7) << 2);
         look(0, up, h, pred, pg);
         pt = pred;
         if ($urandom_range(0, 3) == 0) begin
            pt = $urandom_range(0, 1);
            pg = tg;
         end
         pf = ($urandom_range(0, 3) == 0) ? up : randPc();
         drive(r, e, pf, up, t, tg, pt, pg);
         checkModel();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", nErr, nChk);
      $finish;
   end
endmodule
